// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, redirect request and the IF/ID handshake.
// The fetch unit uses the master modport; the memory/decode side uses slave.
interface instruction_fetch_unit_if #(
   parameter int N = 24
);
   logic         fetch_enable;
   logic [N-1:0] imem_address;
   logic [N-1:0] imem_instruction;
   logic         branch_taken;
   logic [N-1:0] branch_target;
   logic         id_ready;
   logic         if_valid;
   logic [N-1:0] if_instruction;
   logic [N-1:0] if_pc;

   modport master (
      input  fetch_enable, imem_instruction, branch_taken, branch_target, id_ready,
      output imem_address, if_valid, if_instruction, if_pc
   );

   modport slave (
      output fetch_enable, imem_instruction, branch_taken, branch_target, id_ready,
      input  imem_address, if_valid, if_instruction, if_pc
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register driving instruction memory, with a 2-entry {instruction, pc}
// buffer toward decode that absorbs back-pressure and is flushed on a branch redirect.
module instruction_fetch_unit #(
   parameter int           N        = 24,
   parameter logic [N-1:0] RESET_PC = '0
) (
   input logic                  clk,
   input logic                  rst,
   instruction_fetch_unit_if.master bus
);
   logic [N-1:0] pc;
   logic [1:0]   count;
   logic         rd_ptr;
   logic         wr_ptr;
   logic [N-1:0] buf_instr [2];
   logic [N-1:0] buf_pc    [2];

   logic pop;
   logic push;

   assign pop  = bus.if_valid & bus.id_ready;
   // A full buffer still accepts a new word when the head leaves in the same cycle.
   assign push = bus.fetch_enable & ~bus.branch_taken & ((count != 2'd2) | pop);

   assign bus.imem_address   = pc;
   assign bus.if_valid       = (count != 2'd0);
   assign bus.if_instruction = buf_instr[rd_ptr];
   assign bus.if_pc          = buf_pc[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         pc     <= RESET_PC;
         count  <= 2'd0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
      end else if (bus.branch_taken) begin
         // Redirect discards everything buffered, including a head accepted this cycle.
         pc     <= bus.branch_target;
         count  <= 2'd0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
      end else begin
         if (push) begin
            pc     <= pc + 1'b1;
            wr_ptr <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   // Buffer payload carries no reset; it is only observed while if_valid is high.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         buf_instr[wr_ptr] <= bus.imem_instruction;
         buf_pc[wr_ptr]    <= pc;
      end
   end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus random traffic against a
// queue-based model of the fetch buffer; a second instance covers PC wrap-around.
module tb_instruction_fetch_unit;
   localparam int N = 24;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   instruction_fetch_unit_if #(.N(N)) ifc ();
   instruction_fetch_unit_if #(.N(N)) wif ();

   instruction_fetch_unit #(.N(N), .RESET_PC(24'h000000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   instruction_fetch_unit #(.N(N), .RESET_PC(24'hFFFFFE)) dut_w (
      .clk (clk),
      .rst (rst),
      .bus (wif)
   );

   // Instruction memory image: word k holds k + 0x100.
   assign ifc.imem_instruction = ifc.imem_address + 24'h100;
   assign wif.imem_instruction = wif.imem_address + 24'h100;

   int nchk = 0;
   int nerr = 0;

   // Model: next PC to fetch and the ordered list of PCs waiting for decode.
   logic [N-1:0] mpc;
   logic [N-1:0] mq [$];

   task automatic expect_val(string tag, logic [N-1:0] obs, logic [N-1:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check(string tag);
      logic ev;
      ev = (mq.size() != 0);
      nchk++;
      assert (ifc.if_valid === ev) else begin
         nerr++;
         $error("FAIL %s if_valid observed=%b expected=%b", tag, ifc.if_valid, ev);
      end
      expect_val({tag, " imem_address"}, ifc.imem_address, mpc);
      if (mq.size() != 0) begin
         expect_val({tag, " if_pc"}, ifc.if_pc, mq[0]);
         expect_val({tag, " if_instruction"}, ifc.if_instruction, mq[0] + 24'h100);
      end
   endtask

   task automatic model_advance(logic fe, logic br, logic [N-1:0] tgt, logic rdy, logic r);
      if (r) begin
         mq.delete();
         mpc = 24'h000000;
      end else if (br) begin
         mq.delete();
         mpc = tgt;
      end else begin
         if (rdy && mq.size() != 0) void'(mq.pop_front());
         if (fe && mq.size() < 2) begin
            mq.push_back(mpc);
            mpc = mpc + 1'b1;
         end
      end
   endtask

   // One cycle: apply inputs, check the visible state, advance the model, cross the edge.
   task automatic step(logic fe, logic br, logic [N-1:0] tgt, logic rdy, logic r, string tag);
      ifc.fetch_enable  = fe;
      ifc.branch_taken  = br;
      ifc.branch_target = tgt;
      ifc.id_ready      = rdy;
      rst               = r;
      check(tag);
      model_advance(fe, br, tgt, rdy, r);
      @(posedge clk);
      #1;
   endtask

   task automatic wcheck(int k);
      logic [N-1:0] wexp [4];
      wexp = '{24'h000000, 24'hFFFFFE, 24'hFFFFFF, 24'h000000};
      if (k == 0) begin
         expect_val("wrap reset valid", {23'd0, wif.if_valid}, 24'd0);
         expect_val("wrap reset addr", wif.imem_address, 24'hFFFFFE);
      end else begin
         expect_val("wrap valid", {23'd0, wif.if_valid}, 24'd1);
         expect_val("wrap if_pc", wif.if_pc, wexp[k]);
         expect_val("wrap if_instruction", wif.if_instruction, wexp[k] + 24'h100);
      end
   endtask

   initial begin
      wif.fetch_enable  = 1'b1;
      wif.branch_taken  = 1'b0;
      wif.branch_target = '0;
      wif.id_ready      = 1'b1;
      ifc.fetch_enable  = 1'b1;
      ifc.branch_taken  = 1'b1;
      ifc.branch_target = 24'h000055;
      ifc.id_ready      = 1'b1;
      rst               = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      mq.delete();
      mpc = 24'h000000;

      // Reset then stream.
      for (int k = 0; k < 3; k++) begin
         wcheck(k);
         step(1'b1, 1'b0, '0, 1'b1, 1'b0, "stream");
      end

      // Stall with pc 2 at the head.
      wcheck(3);
      expect_val("stall start head", ifc.if_pc, 24'h000002);
      for (int k = 0; k < 4; k++) begin
         if (k >= 2) begin
            expect_val("stall addr frozen", ifc.imem_address, 24'h000004);
            expect_val("stall head pc", ifc.if_pc, 24'h000002);
            expect_val("stall head instr", ifc.if_instruction, 24'h000102);
         end
         step(1'b1, 1'b0, '0, 1'b0, 1'b0, "stall");
      end
      for (int k = 0; k < 3; k++) begin
         expect_val("release pc", ifc.if_pc, 24'(k + 2));
         step(1'b1, 1'b0, '0, 1'b1, 1'b0, "release");
      end

      // Redirect while head is pc 5.
      expect_val("redirect head", ifc.if_pc, 24'h000005);
      step(1'b1, 1'b1, 24'h000040, 1'b1, 1'b0, "redirect");
      expect_val("redirect valid", {23'd0, ifc.if_valid}, 24'd0);
      expect_val("redirect addr", ifc.imem_address, 24'h000040);
      step(1'b1, 1'b0, '0, 1'b1, 1'b0, "redirect+1");
      expect_val("redirect target pc", ifc.if_pc, 24'h000040);
      step(1'b1, 1'b0, '0, 1'b0, 1'b0, "fill");
      step(1'b1, 1'b0, '0, 1'b0, 1'b0, "fill");

      // Redirect with a full buffer and decode stalled.
      step(1'b1, 1'b1, 24'h000010, 1'b0, 1'b0, "full redirect");
      expect_val("full redirect valid", {23'd0, ifc.if_valid}, 24'd0);
      step(1'b1, 1'b0, '0, 1'b0, 1'b0, "full redirect+1");
      expect_val("full redirect pc", ifc.if_pc, 24'h000010);
      step(1'b1, 1'b0, '0, 1'b0, 1'b0, "refill");

      // fetch_enable low: drain, then hold.
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, '0, 1'b1, 1'b0, "fe low");
      expect_val("fe low addr", ifc.imem_address, 24'h000012);
      for (int k = 0; k < 3; k++) step(1'b1, 1'b0, '0, 1'b1, 1'b0, "fe resume");

      // Random traffic.
      for (int k = 0; k < 400; k++) begin
         step(($urandom % 4) != 0, ($urandom % 10) == 0, 24'($urandom),
              ($urandom % 3) != 0, ($urandom % 64) == 0, "random");
      end
      check("final");

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage that drives the instruction memory: holds the program counter, presents it as the read address, captures the returned instruction word and hands it to decode through a 2-entry buffer with a valid/ready handshake. It sits between the instruction memory (asynchronous read, N-bit word address, N-bit word) and the IF/ID boundary. It also absorbs decode back-pressure and branch redirects without losing or duplicating instructions.

## Interface

Parameters:
- N, 24, width of the address, the instruction word and the PC.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- fetch_enable  input  1  when low, no new fetch is issued; the buffer still drains.
- imem_address  output  N  word address to instruction memory; always equals PC (combinational from the PC register).
- imem_instruction  input  N  word returned combinationally by instruction memory for imem_address.
- branch_taken  input  1  redirect request, sampled on the clock edge.
- branch_target  input  N  new PC, used when branch_taken=1.
- id_ready  input  1  decode accepts the head entry this cycle.
- if_valid  output  1  head entry is valid.
- if_instruction  output  N  instruction word of the head entry.
- if_pc  output  N  address the head entry was fetched from.

## Operation

- State: PC register, 2-entry FIFO of {instruction, pc}, 2-bit count (0..2), 1-bit read pointer, 1-bit write pointer.
- pop = if_valid & id_ready.
- push = fetch_enable & ~branch_taken & (count<2 | pop).
- On push:
  - the entry {imem_instruction, PC} is written at the write pointer;
  - PC <= PC+1, modulo 2^N, so all-ones wraps to 0.
- On pop, the read pointer advances.
- count update: next = count + push − pop. Push and pop in the same cycle leave the count unchanged. When count=2 and pop is active, push is allowed in the same cycle.
- Redirect (branch_taken=1) has priority over push and pop:
  - PC <= branch_target;
  - count <= 0 and both pointers <= 0;
  - no entry is written;
  - an id_ready accepted in that same cycle is still a completed transfer of the current head; the entry is then discarded by the flush along with everything else.
- if_valid = (count≠0). if_instruction and if_pc come from the entry at the read pointer.
- While if_valid=1 and id_ready=0, if_instruction and if_pc hold stable.
- The unit does not interpret the instruction word and performs no address range checking; every PC value is issued as-is.

## Timing

- Reset (rst=1 at an edge): PC=RESET_PC, count=0, pointers=0. Next cycle: if_valid=0, imem_address=RESET_PC. if_instruction and if_pc are don't-care while if_valid=0. Reset overrides redirect and fetch.
- Fetch latency: the word at PC is captured at the edge ending the cycle in which PC is presented. It appears on if_valid/if_instruction in the next cycle.
  - First valid output: 1 cycle after rst drops, with fetch_enable=1.
- Throughput: 1 instruction per cycle when id_ready is held at 1.
- Redirect latency: branch_taken sampled at edge E. After E, if_valid=0 and imem_address=branch_target. The target instruction becomes valid after edge E+1.
- Back-pressure: with id_ready=0, the buffer fills in 2 cycles and then PC freezes. When id_ready rises, output resumes with no gap and no skipped or duplicated PC.
- fetch_enable low: PC holds and no push occurs. Entries already buffered are still delivered.
- Reset mid-stream: all buffered entries are dropped. if_valid=0 in the cycle after the reset edge.

## Test plan

- Reset then stream: RESET_PC=0, memory word k = k+0x100, id_ready=1. Required: if_valid=0 in the first cycle after reset; then if_pc=0,1,2,3 on consecutive cycles with if_instruction=0x100,0x101,0x102,0x103.
- Stall: id_ready=0 for 4 cycles, starting while if_pc=2 is at the head. Required:
  - count reaches 2 and imem_address holds at 4;
  - head holds 2/0x102;
  - after release, if_pc=2,3,4,5 with no gaps.
- Redirect: branch_taken=1, branch_target=0x40 while the head is at pc 5. Required: next cycle if_valid=0 and imem_address=0x40; the cycle after, if_pc=0x40; entries 5 and 6 are never accepted after the flush.
- Redirect with full buffer and id_ready=0: count=2, branch_target=0x10. Required: count=0 after the edge; the first valid output is if_pc=0x10.
- Wrap: RESET_PC=0xFFFFFE. Required: if_pc=0xFFFFFE, 0xFFFFFF, 0x000000.
- fetch_enable low for 3 cycles with id_ready=1. Required: the buffered entries drain, then if_valid=0 and imem_address stays constant; fetching resumes at the next sequential PC when fetch_enable returns high.
